// File: rtl/sdr_enc_pkg.sv
// sdr_enc_pkg: shared types and NAF budget-truncation function for sdr_encoder_mx_array
package sdr_enc_pkg;
    localparam int unsigned NAF_MAX_W = 32;
    typedef enum logic {IDLE, SHIFT} state_t;
    // One signed-digit vector: mag[i]=1 means digit i is non-zero, sign[i]=1 means it is -1.
    typedef struct packed {
        logic [NAF_MAX_W:0] mag;
        logic [NAF_MAX_W:0] sign;
    } naf_t;
    // NAF of value, then keep only the first `budget` non-zero digits scanning from the MSB.
    function automatic naf_t naf_trunc(input logic [NAF_MAX_W-1:0] value, input int unsigned budget,
                                       input int unsigned budget_max);
        naf_t r;
        logic [NAF_MAX_W+1:0] x;
        int unsigned keep;
        int unsigned cnt;
        r = '0;
        x = {2'b00, value};
        keep = (budget > budget_max) ? budget_max : budget;
        cnt = 0;
        // x mod 4 == 3 gives digit -1 (round up), x mod 4 == 1 gives +1 (round down).
        for (int i = 0; i <= NAF_MAX_W; i++) begin
            if (x[0]) begin
                r.mag[i] = 1'b1;
                r.sign[i] = x[1];
                x = x[1] ? x + 1'b1 : x - 1'b1;
            end
            x = x >> 1;
        end
        for (int i = NAF_MAX_W; i >= 0; i--) begin
            if (r.mag[i]) begin
                if (cnt >= keep) begin
                    r.mag[i] = 1'b0;
                    r.sign[i] = 1'b0;
                end else begin
                    cnt++;
                end
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/sdr_lane_serializer.sv
// sdr_lane_serializer: encodes one word on load, then shifts its NAF digits out MSB first
//   load_i/data_i/budget_i : capture and encode a word
//   adv_i                  : advance to the next lower digit
//   mag_o/sign_o           : current digit
//   resid_o                : original minus truncated value (only with SDR_ENC_RESIDUAL_EN)
module sdr_lane_serializer
    import sdr_enc_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned BW = 2,
    parameter int unsigned BUDGET_MAX = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic              adv_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [BW-1:0]     budget_i,
    output logic              mag_o,
    output logic              sign_o
`ifdef SDR_ENC_RESIDUAL_EN
    ,
    output logic [DATA_W+1:0] resid_o
`endif
);
    naf_t n;
    logic [DATA_W:0] mag_q, mag_d, sign_q, sign_d;
    logic unused_hi;
    always_comb begin
        n = naf_trunc(NAF_MAX_W'(data_i), 32'(budget_i), BUDGET_MAX);
        mag_d = load_i ? n.mag[DATA_W:0] : adv_i ? {mag_q[DATA_W-1:0], 1'b0} : mag_q;
        sign_d = load_i ? n.sign[DATA_W:0] : adv_i ? {sign_q[DATA_W-1:0], 1'b0} : sign_q;
        unused_hi = ^{n.mag[NAF_MAX_W:DATA_W+1], n.sign[NAF_MAX_W:DATA_W+1]};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mag_q <= '0;
            sign_q <= '0;
        end else begin
            mag_q <= mag_d;
            sign_q <= sign_d;
        end
    end
    assign mag_o = mag_q[DATA_W];
    assign sign_o = sign_q[DATA_W];
`ifdef SDR_ENC_RESIDUAL_EN
    logic [DATA_W+1:0] resid_q, resid_d;
    logic [DATA_W:0] pos, neg;
    always_comb begin
        pos = n.mag[DATA_W:0] & ~n.sign[DATA_W:0];
        neg = n.mag[DATA_W:0] & n.sign[DATA_W:0];
        resid_d = load_i ? {2'b00, data_i} - {1'b0, pos} + {1'b0, neg} : resid_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) resid_q <= '0;
        else resid_q <= resid_d;
    end
    assign resid_o = resid_q;
`endif
endmodule

// File: rtl/sdr_encoder_mx_array.sv
// sdr_encoder_mx_array: collects LANES words, emits budget-truncated NAF digits bit-serially, MSB first
//   in_valid/in_ready/in_data/in_last    : word stream into the collect buffer
//   out_valid/out_ready                  : digit-slice handshake
//   out_mag/out_sign/out_first/out_last  : per-lane digit of the current slice
//   enable freezes everything; budget is sampled at group launch
//   optional out_resid under macro SDR_ENC_RESIDUAL_EN
module sdr_encoder_mx_array
    import sdr_enc_pkg::*;
#(
    parameter int unsigned LANES = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned BUDGET_MAX = 3,
    localparam int unsigned BW = $clog2(BUDGET_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [BW-1:0]     budget,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANES-1:0]  out_mag,
    output logic [LANES-1:0]  out_sign,
    output logic              out_first,
    output logic              out_last
`ifdef SDR_ENC_RESIDUAL_EN
    ,
    output logic [LANES*(DATA_W+2)-1:0] out_resid
`endif
);
    localparam int unsigned PW = $clog2(LANES);
    localparam int unsigned IW = $clog2(DATA_W + 1);
    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic full_q, full_d, go_q;
    logic [DATA_W-1:0] buf_q [LANES];
    logic [DATA_W-1:0] buf_d [LANES];
    logic [DATA_W-1:0] src [LANES];
    logic busy, acc, done, hs, last_hs, launch;
    logic [LANES-1:0] mag_b, sign_b;
    assign busy = state_q == SHIFT;
    assign in_ready = go_q & enable & !(full_q & busy);
    assign acc = in_valid & in_ready;
    assign done = acc & ((ptr_q == PW'(LANES - 1)) | in_last);
    assign hs = enable & busy & out_ready;
    assign last_hs = hs & (idx_q == '0);
    // A group completing this cycle is loaded straight from the merged buffer (no bubble).
    assign launch = enable & (full_q | done) & (!busy | last_hs);
    assign out_valid = busy;
    assign out_first = busy & (idx_q == IW'(DATA_W));
    assign out_last = busy & (idx_q == '0);
    assign out_mag = busy ? mag_b : '0;
    assign out_sign = busy ? sign_b : '0;
    always_comb begin
        ptr_d = done ? '0 : acc ? ptr_q + 1'b1 : ptr_q;
        // If a full buffer launches while lane 0 of the next group arrives, keep only the new group pending.
        full_d = launch ? (full_q & done) : (full_q | done);
        for (int i = 0; i < LANES; i++) begin
            buf_d[i] = (acc && PW'(i) == ptr_q) ? in_data : (done && PW'(i) > ptr_q) ? '0 : buf_q[i];
            src[i] = full_q ? buf_q[i] : buf_d[i];
        end
    end
    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        if (launch) begin
            state_d = SHIFT;
            idx_d = IW'(DATA_W);
        end else if (last_hs) begin
            state_d = IDLE;
        end else if (hs) begin
            idx_d = idx_q - 1'b1;
        end
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q <= '0;
            ptr_q <= '0;
            full_q <= 1'b0;
            go_q <= 1'b0;
            buf_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            ptr_q <= ptr_d;
            full_q <= full_d;
            go_q <= 1'b1;
            buf_q <= buf_d;
        end
    end
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sdr_lane_serializer #(
            .DATA_W(DATA_W),
            .BW(BW),
            .BUDGET_MAX(BUDGET_MAX)
        ) u_ser (
            .clk(clk),
            .reset_n(reset_n),
            .load_i(launch),
            .adv_i(hs),
            .data_i(src[g]),
            .budget_i(budget),
            .mag_o(mag_b[g]),
            .sign_o(sign_b[g])
`ifdef SDR_ENC_RESIDUAL_EN
            ,
            .resid_o(out_resid[g*(DATA_W+2) +: DATA_W+2])
`endif
        );
    end
endmodule

// File: doc/sdr_encoder_mx_array.md
Name: sdr_encoder_mx_array

Overview:
- Parametrised successor to the fixed 8-lane, 8-bit SDR encoder array.
- Gathers LANES unsigned words from a single input stream into a collect buffer through a valid/ready handshake.
- Converts each word to budget-truncated non-adjacent form (NAF) signed digits and emits all lanes in parallel, bit-serial, MSB first.
- Sits between the activation buffer and the bit-serial MAC array; collection of group k+1 overlaps serialisation of group k.

Parameters:
- LANES, 8, number of parallel lanes (words per group), >=2.
- DATA_W, 8, input word width in bits; each word produces DATA_W+1 digits.
- BUDGET_MAX, 3, largest non-zero-digit budget supported; budget port width BW = $clog2(BUDGET_MAX+1).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  global advance; when low, all state holds and in_ready = 0.
- budget  in  BW  number of non-zero digits kept per word; sampled when a group launches.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  DATA_W  unsigned input word.
- in_last  in  1  with the accepted word: close the group early; remaining lanes are zero-filled.
- out_valid  out  1  digit slice valid.
- out_ready  in  1  downstream accepts the slice.
- out_mag  out  LANES  per lane: 1 = digit non-zero.
- out_sign  out  LANES  per lane: 1 = digit is -1; 0 whenever out_mag is 0.
- out_first  out  1  slice is digit position DATA_W (the MSB).
- out_last  out  1  slice is digit position 0.

Behaviour:
- Reset (async, reset_n low): all outputs 0, buffers cleared, lane pointer 0, FSM in IDLE. in_ready rises on the first clock edge after release.
- Collect:
  - An accepted word (in_valid & in_ready & enable) is written to lane[ptr], then ptr increments.
  - A group completes when ptr reaches LANES-1 or in_last is accepted. ptr then wraps to 0 and higher lanes are zero-filled.
  - in_ready = enable & !(collect buffer complete & serialiser busy).
- Encode per lane:
  - Digits are the NAF of the value (DATA_W+1 digits; no two adjacent digits non-zero).
  - Scanning from the MSB, keep the first `budget` non-zero digits and zero the rest.
  - budget = 0 gives all-zero digits; budget > BUDGET_MAX saturates to BUDGET_MAX.
- FSM:
  - IDLE -> SHIFT when a complete group is present. Load happens on the edge after the completing handshake, so out_valid rises 1 cycle after that handshake.
  - SHIFT: a slice advances only on out_valid & out_ready. On out_first, the slice index is DATA_W; it decrements to 0 (out_last).
  - On a handshaked out_last, go to SHIFT with the next group loaded on the same edge if one is complete (no bubble); otherwise go to IDLE and drop out_valid.
- Backpressure: while out_valid & !out_ready, out_mag, out_sign, out_first and out_last hold stable.
- Simultaneous events: a group completing on the same cycle as a handshaked out_last is loaded directly into the serialiser. The collect buffer is free again that same cycle.
- enable low mid-operation freezes everything, including outputs; no data is lost.
- budget changes during SHIFT have no effect until the next group launch.

Optional Feature:
- Macro: SDR_ENC_RESIDUAL_EN.
- Defined: adds output out_resid [LANES*(DATA_W+2)], per lane the signed value (original minus truncated value), two's complement. It is valid with the out_first slice and held through the group.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Package sdr_enc_pkg holds:
  - a NAF/truncate function (value, budget) -> {mag, sign} vectors;
  - digit-slice struct typedef;
  - FSM state enum (IDLE, SHIFT).
- Sub-module sdr_lane_serializer, one instance per lane:
  - loads a word, encodes it with the package function, and shifts mag/sign MSB first under a shared advance strobe.
  - the top level owns the collect buffer, lane pointer, handshakes and FSM.

Test Plan:
- Word 93 (0x5D) in lane 0, LANES=8, budget=3, other lanes 0: NAF +128 -32 -4 +1. The 9 slices, MSB first, give lane-0 mag 0,1,0,1,0,0,1,0,0 with sign 1 at positions 5 and 2. Residual (if enabled) = +1.
- Same word with budget=2: non-zero digits only at positions 7 and 5 (truncated value 96); with budget=0, all-zero digits.
- Word 7 with budget=2: slices show +1 at position 3 and -1 at position 0 (8-1). out_first on the first slice, out_last on the 9th.
- Back-to-back groups with out_ready=1: second group complete before the first finishes. in_ready drops, then slice 0 of group 2 follows group 1's out_last with no idle cycle.
- in_last on the 3rd word: lanes 3-7 emit zeros and ptr restarts at 0. Hold out_ready=0 for 4 cycles mid-group: slices stay stable, none lost.
- Assert reset_n low mid-SHIFT: outputs 0 immediately (asynchronous). A fresh group after release encodes correctly; enable=0 for 5 cycles freezes state.
